// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle MIPS datapath. Outputs are Moore-decoded from state.
// The exceptions are the FETCH ir_write/pc_write strobes (qualified by mem_ready) and the wait-limit timeout pulse.
module multicycle_controller #(
    parameter int FETCH_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal,
    output logic       timeout,
    output logic [3:0] state
);

    localparam int CW = (FETCH_WAIT_MAX > 1) ? $clog2(FETCH_WAIT_MAX + 1) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_RD    = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WR    = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
        JR        = 4'd12
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_wait_cnt;
    logic            r_illegal;
    logic            w_waiting;
    logic            w_timeout;
    logic            w_legal;
    logic            w_funct_ok;

    // zero is consumed by the datapath's beq PC gating, not by the sequencer.
    logic            w_unused;
    assign w_unused = zero;

    assign w_waiting = ((r_state == FETCH) || (r_state == MEM_RD) || (r_state == MEM_WR)) && !mem_ready;
    // Fires on the FETCH_WAIT_MAX-th consecutive wait cycle itself, not one cycle later.
    assign w_timeout = (FETCH_WAIT_MAX != 0) && w_waiting && (int'(r_wait_cnt) == FETCH_WAIT_MAX - 1);

    assign w_funct_ok = (funct == 6'b100000) || (funct == 6'b100010) || (funct == 6'b100100) ||
                        (funct == 6'b100101) || (funct == 6'b101010) || (funct == FN_JR);
    assign w_legal    = ((opcode == OP_RTYPE) && w_funct_ok) || (opcode == OP_LW) || (opcode == OP_SW) ||
                        (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FETCH;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= (r_state == DECODE) && !w_legal;
            if (!w_waiting || w_timeout || (FETCH_WAIT_MAX == 0))
                r_wait_cnt <= '0;
            else
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            FETCH:     if (mem_ready) w_next = DECODE;
            DECODE: begin
                if (!w_legal)                                   w_next = FETCH;
                else if (opcode == OP_RTYPE && funct == FN_JR)  w_next = JR;
                else if (opcode == OP_RTYPE)                    w_next = R_EXEC;
                else if (opcode == OP_LW || opcode == OP_SW)    w_next = MEM_ADDR;
                else if (opcode == OP_BEQ)                      w_next = BRANCH;
                else if (opcode == OP_ADDI)                     w_next = ADDI_EXEC;
                else                                            w_next = JUMP;
            end
            MEM_ADDR:  w_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:    if (mem_ready) w_next = MEM_WB;
            MEM_WR:    if (mem_ready) w_next = FETCH;
            R_EXEC:    w_next = R_WB;
            ADDI_EXEC: w_next = ADDI_WB;
            MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP, JR: w_next = FETCH;
            default:   w_next = FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        unique case (r_state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE:    alu_src_b = 2'b11;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDI_WB:   reg_write = 1'b1;
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            JR: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
            end
            default: ;
        endcase
    end

    assign illegal = r_illegal;
    assign timeout = w_timeout;
    assign state   = r_state;

endmodule
